// File: rtl/chunked_add_pkg.sv
// Shared types and elaboration helpers for the chunked adder sequencer.
// Provides the controller state encoding, the idx width rule and the CHUNKS legality check.
package chunked_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNKS_MIN = 1;
    localparam int CHUNKS_MAX = 16;

    // idx needs clog2(CHUNKS) bits, but a zero-width counter is not legal.
    function automatic int idx_width(input int chunks);
        return (chunks <= 1) ? 1 : $clog2(chunks);
    endfunction

    function automatic bit chunks_legal(input int chunks);
        return (chunks >= CHUNKS_MIN) && (chunks <= CHUNKS_MAX);
    endfunction

endpackage

// File: rtl/chunked_add_sequencer_chunk_select.sv
// chunk_select: returns SIZE-bit chunk number idx of a SIZE*CHUNKS-bit vector.
// Written as a compare-and-select so an out-of-range idx can never index past the vector.
module chunk_select
    import chunked_add_pkg::*;
#(
    parameter int SIZE   = 128,
    parameter int CHUNKS = 4,
    localparam int IW    = idx_width(CHUNKS)
) (
    input  logic [SIZE*CHUNKS-1:0] vec,
    input  logic [IW-1:0]          idx,
    output logic [SIZE-1:0]        chunk
);

    always_comb begin
        chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
                chunk = vec[i*SIZE +: SIZE];
            end
        end
    end

endmodule

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: drives an external SIZE-bit tree adder one chunk per cycle to form a SIZE*CHUNKS-bit sum.
// Optional macro CHUNKED_ADD_OVF_EN adds the out_ovf port (signed overflow of the full-width add).
module chunked_add_sequencer
    import chunked_add_pkg::*;
#(
    parameter int SIZE   = 128,
    parameter int CHUNKS = 4,
    localparam int W     = SIZE * CHUNKS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic            in_cin,
    output logic [SIZE-1:0] add_a,
    output logic [SIZE-1:0] add_b,
    output logic            add_cin,
    input  logic [SIZE-1:0] add_sum,
    input  logic            add_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_sum,
    output logic            out_cout,
    output logic            busy,
    output logic [1:0]      dbg_state
`ifdef CHUNKED_ADD_OVF_EN
    ,
    output logic            out_ovf
`endif
);

    localparam int IW = idx_width(CHUNKS);

    if (!chunks_legal(CHUNKS)) begin : g_bad_chunks
        $error("chunked_add_sequencer: CHUNKS must be within 1..16");
    end

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic [SIZE-1:0] a_chunk;
    logic [SIZE-1:0] b_chunk;
    logic            last;
    logic            running;
`ifdef CHUNKED_ADD_OVF_EN
    logic            ovf_q;
`endif

    chunk_select #(.SIZE(SIZE), .CHUNKS(CHUNKS)) u_sel_a (
        .vec   (a_q),
        .idx   (idx),
        .chunk (a_chunk)
    );

    chunk_select #(.SIZE(SIZE), .CHUNKS(CHUNKS)) u_sel_b (
        .vec   (b_q),
        .idx   (idx),
        .chunk (b_chunk)
    );

    assign last    = (idx == IW'(CHUNKS - 1));
    assign running = (state == RUN);

    // Operand and result registers carry no reset: an aborted add leaves stale data
    // that is hidden by the out_valid gating on out_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
`ifdef CHUNKED_ADD_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < CHUNKS; i++) begin
                        if (idx == IW'(i)) begin
                            result_q[i*SIZE +: SIZE] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        state <= DONE;
`ifdef CHUNKED_ADD_OVF_EN
                        ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[SIZE-1] != a_q[W-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign out_sum   = out_valid ? result_q : '0;
    assign out_cout  = carry;
    assign add_a     = running ? a_chunk : '0;
    assign add_b     = running ? b_chunk : '0;
    assign add_cin   = running & carry;
`ifdef CHUNKED_ADD_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed bench for chunked_add_sequencer with SIZE=8, CHUNKS=4 and a behavioural tree adder.
// Covers out_ovf as well when built with CHUNKED_ADD_OVF_EN.
module tb_chunked_add_sequencer;

    localparam int SIZE   = 8;
    localparam int CHUNKS = 4;
    localparam int W      = SIZE * CHUNKS;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_cin;
    logic [SIZE-1:0] add_a;
    logic [SIZE-1:0] add_b;
    logic            add_cin;
    logic [SIZE-1:0] add_sum;
    logic            add_cout;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_sum;
    logic            out_cout;
    logic            busy;
    logic [1:0]      dbg_state;
`ifdef CHUNKED_ADD_OVF_EN
    logic            out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    // behavioural tree adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SIZE{1'b0}}, add_cin};

    chunked_add_sequencer #(.SIZE(SIZE), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef CHUNKED_ADD_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // driver: called at a negedge with in_ready high; returns at the negedge after the accept edge
    task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // counts edges until out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({out_sum, out_cout} !== 33'h0) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/0", out_sum, out_cout); end
        checks++; if ({add_a, add_b, add_cin} !== 17'h0) begin failures++; $display("FAIL reset_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        start_req(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checks++; if ({add_a, add_b, add_cin} !== {8'hFF, 8'h01, 1'b0}) begin failures++; $display("FAIL ripple_chunk0 got=%h/%h/%b exp=ff/01/0", add_a, add_b, add_cin); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ripple_run_flags got=%b/%b exp=0/1", in_ready, busy); end
        @(negedge clk);
        checks++; if ({add_a, add_b, add_cin} !== {8'hFF, 8'h00, 1'b1}) begin failures++; $display("FAIL ripple_chunk1 got=%h/%h/%b exp=ff/00/1", add_a, add_b, add_cin); end
        wait_valid(lat);
        checks++; if (lat + 1 != CHUNKS) begin failures++; $display("FAIL ripple_latency got=%0d exp=%0d", lat + 1, CHUNKS); end
        checks++; if (out_sum !== 32'h0000_0000 || out_cout !== 1'b1) begin failures++; $display("FAIL ripple_result got=%h/%b exp=00000000/1", out_sum, out_cout); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ripple_done_in_ready got=%b exp=0", in_ready); end
        checks++; if ({add_a, add_b, add_cin} !== 17'h0) begin failures++; $display("FAIL ripple_done_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        handshake();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ripple_release got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_latency();
        int lat;
        start_req(32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_valid(lat);
        checks++; if (lat != CHUNKS) begin failures++; $display("FAIL latency got=%0d exp=%0d", lat, CHUNKS); end
        checks++; if (out_sum !== 32'h2345_678A || out_cout !== 1'b0) begin failures++; $display("FAIL latency_result got=%h/%b exp=2345678a/0", out_sum, out_cout); end
        handshake();
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        start_req(32'h0000_FFFF, 32'h0000_0001, 1'b1);
        in_a = 32'hDEAD_BEEF; in_b = 32'h1234_0000; in_cin = 1'b0;
        in_valid = 1'b1;   // ignored while busy
        wait_valid(lat);
        checks++; if (out_sum !== 32'h0001_0001 || out_cout !== 1'b0) begin failures++; $display("FAIL stall_result got=%h/%b exp=00010001/0", out_sum, out_cout); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h0001_0001 || out_cout !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d_bad_cycles exp=0", bad); end
        in_valid = 1'b0;
        handshake();
        checks++; if (dbg_state !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0d/%b/%b exp=0/1/0", dbg_state, in_ready, out_valid); end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_no_queue got=%0d_bad_cycles exp=0", bad); end
    endtask

    task automatic test_reset_abort();
        int bad;
        start_req(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(negedge clk);
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL abort_in_run got=%0d exp=1", dbg_state); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (dbg_state !== 2'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_state got=%0d/%b/%b exp=0/1/0", dbg_state, in_ready, busy); end
        checks++; if (out_sum !== 32'h0 || out_cout !== 1'b0) begin failures++; $display("FAIL abort_out got=%h/%b exp=0/0", out_sum, out_cout); end
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_no_valid got=%0d_bad_cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back();
        int k;
        int overlap;
        int lat;
        logic [W-1:0] sum1;
        logic         cout1;
        sum1 = '0; cout1 = 1'bx; overlap = 0;
        out_ready = 1'b1;
        start_req(32'h0000_0001, 32'h0000_0002, 1'b0);
        k = 0;
        while (!in_ready && k < 20) begin
            if (out_valid) begin sum1 = out_sum; cout1 = out_cout; end
            @(negedge clk);
            k++;
            if (in_ready && out_valid) overlap++;
        end
        checks++; if (sum1 !== 32'h0000_0003 || cout1 !== 1'b0) begin failures++; $display("FAIL b2b_first got=%h/%b exp=00000003/0", sum1, cout1); end
        checks++; if (k + 1 != CHUNKS + 2) begin failures++; $display("FAIL b2b_interval got=%0d exp=%0d", k + 1, CHUNKS + 2); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
        start_req(32'hFFFF_0000, 32'h0001_0000, 1'b1);
        wait_valid(lat);
        checks++; if (lat != CHUNKS || out_sum !== 32'h0000_0001 || out_cout !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d/%h/%b exp=4/00000001/1", lat, out_sum, out_cout); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

`ifdef CHUNKED_ADD_OVF_EN
    task automatic test_ovf();
        int lat;
        start_req(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(lat);
        checks++; if (out_sum !== 32'h8000_0000 || out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pos got=%h/%b exp=80000000/1", out_sum, out_ovf); end
        handshake();
        start_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        wait_valid(lat);
        checks++; if (out_sum !== 32'hFFFF_FFFF || out_ovf !== 1'b0) begin failures++; $display("FAIL ovf_mixed got=%h/%b exp=ffffffff/0", out_sum, out_ovf); end
        handshake();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_carry_ripple();
        test_latency();
        test_stall();
        test_reset_abort();
        test_back_to_back();
`ifdef CHUNKED_ADD_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chunked_add_sequencer.md
# chunked_add_sequencer

Multi-cycle controller that performs additions wider than the tree adder by splitting them into SIZE-bit chunks. It sits on both sides of the existing combinational tree adder: it drives the adder's a/b/cin operand inputs and captures its sum/cout outputs each cycle. It propagates the carry from chunk to chunk and returns one full-width result through a valid/ready handshake.

## Interface
Parameters:
- SIZE, 128, width of the attached tree adder in bits.
- CHUNKS, 4, number of SIZE-bit chunks per operand. The full width is W = SIZE*CHUNKS. Legal range is 1..16.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in to chunk 0.
- add_a  out  SIZE  current chunk of A, driven to the adder's a input.
- add_b  out  SIZE  current chunk of B, driven to the adder's b input.
- add_cin  out  1  running carry, driven to the adder's cin input.
- add_sum  in  SIZE  adder sum output (combinational, same cycle).
- add_cout  in  1  adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  full-width sum.
- out_cout  out  1  final carry-out.
- busy  out  1  high in RUN or DONE.

## Operation
The controller is a three-state machine: IDLE, RUN, DONE.

IDLE:
- in_ready=1.
- When in_valid=1, on the next edge:
  - latch in_a, in_b into operand registers;
  - carry register <= in_cin;
  - idx <= 0;
  - go to RUN.

RUN:
- in_ready=0.
- add_a = A[idx*SIZE +: SIZE], add_b = B[idx*SIZE +: SIZE], add_cin = carry register.
- Each edge:
  - result[idx*SIZE +: SIZE] <= add_sum;
  - carry <= add_cout;
  - idx <= idx+1.
- On the edge where idx==CHUNKS-1: perform the capture, then go to DONE.

DONE:
- out_valid=1.
- out_sum and out_cout hold the captured result; out_cout = carry register.
- When out_ready=1: go to IDLE on that edge.
- Outputs stay stable while out_ready=0.

Rules and boundary conditions:
- idx width is clog2(CHUNKS), with a minimum of 1. With CHUNKS=1, RUN lasts exactly one cycle.
- in_valid while busy is ignored; no request is queued.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Arithmetic is unsigned modulo 2^W. out_cout is bit W of A+B+cin.
- Reset asserted mid-operation aborts the operation: state=IDLE, and any partial result is discarded (but not cleared, see below).

## Timing
Reset values:
- in_ready=1, out_valid=0, busy=0.
- out_sum=0, out_cout=0.
- add_a, add_b, add_cin = 0.
- idx=0, carry=0, state=IDLE.

Latency and throughput:
- A request accepted at edge E0 produces out_valid high starting after edge E0+CHUNKS.
- Minimum initiation interval is CHUNKS+2 cycles with out_ready held at 1. This is one DONE cycle plus one IDLE cycle.
- in_ready is never high in the same cycle as out_valid.
- The adder path is combinational within one cycle: the add_* outputs to add_sum/add_cout inputs must close timing in one clk period.

## Configuration
- Macro CHUNKED_ADD_OVF_EN.
- Defined: adds output port out_ovf (1 bit) with two's-complement overflow of the full-width add:
  - out_ovf = (A[W-1]==B[W-1]) && (out_sum[W-1]!=A[W-1]);
  - it is registered in the final RUN capture;
  - it is valid with out_valid and resets to 0.
- Undefined: no out_ovf port and no related logic.

## Structure
- Package chunked_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam function for the idx width;
  - the CHUNKS legality check constant.
- One sub-module, chunk_select: parameterised SIZE/CHUNKS slicer that returns chunk idx of a W-bit vector. It is instantiated twice, for A and B.
- The result register and carry register stay in the top module.

## Test plan
Bench uses SIZE=8, CHUNKS=4, with a behavioural adder model attached to add_*.
- Reset, then idle -> in_ready=1, out_valid=0, all outputs 0.
- A=0xFFFFFFFF, B=0x00000001, cin=0 -> carry ripples through all chunks; after 4 cycles out_sum=0x00000000, out_cout=1.
- A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0. out_valid rises exactly 4 cycles after acceptance.
- Result presented with out_ready=0 for 5 cycles, then 1 -> out_sum stable throughout; in_valid pulsed during busy is ignored; IDLE is re-entered after the handshake.
- rst asserted in the 2nd RUN cycle -> next cycle state=IDLE, in_ready=1, and no out_valid occurs for the aborted request.
- With CHUNKED_ADD_OVF_EN: A=0x7FFFFFFF, B=0x00000001 -> out_ovf=1; A=0x80000000, B=0x7FFFFFFF -> out_ovf=0.
